// File: rtl/csr_ctrl.sv
// Execute-stage CSR access and trap/return sequencer driving a single-port CSR file.
// Zicsr: 1 cycle after accept; ECALL: 4 cycles (redirect in the last); MRET: 2 cycles. Accepts only in IDLE.
module csr_ctrl #(
  parameter int XLEN        = 32,
  parameter int ECALL_CAUSE = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr,
  input  logic [4:0]      req_rs1_idx,
  input  logic [XLEN-1:0] req_rs1_data,
  input  logic [XLEN-1:0] req_pc,
  input  logic            req_ecall,
  input  logic            req_mret,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            csr_wen,
  output logic [XLEN-1:0] csr_read_addr,
  output logic [XLEN-1:0] csr_write_addr,
  output logic [XLEN-1:0] csr_write_data,
  input  logic [XLEN-1:0] csr_read_data
);

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE, S_CSR, S_T_EPC, S_T_CAUSE, S_T_STAT, S_T_VEC, S_R_STAT, S_R_EPC
  } state_e;

  state_e            state_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rs1_idx_q;
  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   pc_q;
  logic [11:0]       addr_q;
  logic              wen_q;
  logic              ready_q;
  logic              resp_valid_q;
  logic              illegal_q;
  logic              redirect_valid_q;

  // Control outputs for each state are computed on the edge that enters it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      funct3_q         <= '0;
      rs1_idx_q        <= '0;
      rs1_data_q       <= '0;
      pc_q             <= '0;
      addr_q           <= '0;
      wen_q            <= 1'b0;
      ready_q          <= 1'b1;
      resp_valid_q     <= 1'b0;
      illegal_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
    end else begin
      addr_q           <= '0;
      wen_q            <= 1'b0;
      ready_q          <= 1'b0;
      resp_valid_q     <= 1'b0;
      illegal_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            funct3_q   <= req_funct3;
            rs1_idx_q  <= req_rs1_idx;
            rs1_data_q <= req_rs1_data;
            pc_q       <= req_pc;
            if (req_ecall) begin
              state_q <= S_T_EPC;
              addr_q  <= MEPC;
              wen_q   <= 1'b1;
            end else if (req_mret) begin
              state_q <= S_R_STAT;
              addr_q  <= MSTATUS;
              wen_q   <= 1'b1;
            end else begin
              state_q      <= S_CSR;
              resp_valid_q <= 1'b1;
              if (req_funct3[1:0] == 2'b00) begin
                illegal_q <= 1'b1;
              end else begin
                addr_q <= req_csr;
                // Set/clear with x0/zimm=0 must not write (no side effects on read-only CSRs).
                wen_q  <= (req_funct3[1:0] == 2'b01) || (req_rs1_idx != 5'd0);
              end
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_T_EPC: begin
          state_q <= S_T_CAUSE;
          addr_q  <= MCAUSE;
          wen_q   <= 1'b1;
        end
        S_T_CAUSE: begin
          state_q <= S_T_STAT;
          addr_q  <= MSTATUS;
          wen_q   <= 1'b1;
        end
        S_T_STAT: begin
          state_q          <= S_T_VEC;
          addr_q           <= MTVEC;
          redirect_valid_q <= 1'b1;
        end
        S_R_STAT: begin
          state_q          <= S_R_EPC;
          addr_q           <= MEPC;
          redirect_valid_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  logic [XLEN-1:0] src;
  logic [XLEN-1:0] stat_trap;
  logic [XLEN-1:0] stat_ret;
  logic [XLEN-1:0] wdata;

  assign src = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_data_q;

  always_comb begin
    stat_trap        = csr_read_data;
    stat_trap[7]     = csr_read_data[3];
    stat_trap[3]     = 1'b0;
    stat_trap[12:11] = 2'b11;
    stat_ret         = csr_read_data;
    stat_ret[3]      = csr_read_data[7];
    stat_ret[7]      = 1'b1;
    stat_ret[12:11]  = 2'b11;
  end

  always_comb begin
    wdata = '0;
    if (wen_q) begin
      case (state_q)
        S_CSR: begin
          case (funct3_q[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = csr_read_data | src;
            2'b11:   wdata = csr_read_data & ~src;
            default: wdata = '0;
          endcase
        end
        S_T_EPC:   wdata = {pc_q[XLEN-1:2], 2'b00};
        S_T_CAUSE: wdata = XLEN'(ECALL_CAUSE);
        S_T_STAT:  wdata = stat_trap;
        S_R_STAT:  wdata = stat_ret;
        default:   wdata = '0;
      endcase
    end
  end

  assign req_ready      = ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_illegal   = illegal_q;
  assign resp_rdata     = (resp_valid_q && !illegal_q) ? csr_read_data : '0;
  assign redirect_valid = redirect_valid_q;
  // Both trap vector and mepc targets are word-aligned; vectored mtvec is ignored for exceptions.
  assign redirect_pc    = redirect_valid_q ? {csr_read_data[XLEN-1:2], 2'b00} : '0;
  assign csr_wen        = wen_q;
  assign csr_read_addr  = {{(XLEN-12){1'b0}}, addr_q};
  assign csr_write_addr = {{(XLEN-12){1'b0}}, addr_q};
  assign csr_write_data = wdata;

endmodule

// File: tb/tb_csr_ctrl.sv
// Bench for csr_ctrl: CSR-file model, Zicsr vector table, ECALL/MRET/reset sequences, event scoreboard.
module tb_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_ecall, req_mret;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr;
  logic [4:0]  req_rs1_idx;
  logic [31:0] req_rs1_data, req_pc;
  logic        resp_valid, resp_illegal, redirect_valid, csr_wen;
  logic [31:0] resp_rdata, redirect_pc, csr_read_addr, csr_write_addr, csr_write_data, csr_read_data;

  always #5 clk = ~clk;

  csr_ctrl #(.XLEN(32), .ECALL_CAUSE(11)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_csr(req_csr), .req_rs1_idx(req_rs1_idx),
    .req_rs1_data(req_rs1_data), .req_pc(req_pc),
    .req_ecall(req_ecall), .req_mret(req_mret),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .csr_wen(csr_wen), .csr_read_addr(csr_read_addr), .csr_write_addr(csr_write_addr),
    .csr_write_data(csr_write_data), .csr_read_data(csr_read_data)
  );

  // CSR file model: combinational read, write on the edge; preload port used only while idle.
  logic [31:0] csr_mem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  assign csr_read_data = csr_mem[csr_read_addr[11:0]];
  always @(posedge clk) begin
    if (csr_wen) csr_mem[csr_write_addr[11:0]] <= csr_write_data;
    else if (pl_en) csr_mem[pl_addr] <= pl_data;
  end

  int checks = 0;
  int errors = 0;

  typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] rdata; logic ill; } rsp_t;
  wr_t         wq[$];
  rsp_t        rq[$];
  logic [31:0] dq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every output event must match the oldest expectation of its kind.
  always @(negedge clk) begin
    if (!rst) begin
      if (csr_wen) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL sb_wen unexpected write addr=%h data=%h", csr_write_addr, csr_write_data);
        end else begin
          wr_t w;
          w = wq.pop_front();
          if (csr_write_addr !== {20'd0, w.addr} || csr_write_data !== w.data) begin
            errors++;
            $display("FAIL sb_wen actual=%h:%h required=%h:%h", csr_write_addr, csr_write_data, w.addr, w.data);
          end
        end
      end
      if (resp_valid) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL sb_resp unexpected rdata=%h", resp_rdata);
        end else begin
          rsp_t r;
          r = rq.pop_front();
          if (resp_rdata !== r.rdata || resp_illegal !== r.ill) begin
            errors++;
            $display("FAIL sb_resp actual=%h/%b required=%h/%b", resp_rdata, resp_illegal, r.rdata, r.ill);
          end
        end
      end
      if (redirect_valid) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL sb_redir unexpected pc=%h", redirect_pc);
        end else begin
          logic [31:0] p;
          p = dq.pop_front();
          if (redirect_pc !== p) begin
            errors++;
            $display("FAIL sb_redir actual=%h required=%h", redirect_pc, p);
          end
        end
      end
      if (resp_valid && redirect_valid) begin
        errors++;
        $display("FAIL resp_redir_overlap actual=1 required=0");
      end
      if (!csr_wen && csr_write_data !== 32'd0) begin
        errors++;
        $display("FAIL wdata_idle actual=%h required=0", csr_write_data);
      end
      if (csr_wen && csr_read_addr !== csr_write_addr) begin
        errors++;
        $display("FAIL addr_eq actual=%h required=%h", csr_read_addr, csr_write_addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                       input logic [31:0] d, input logic [31:0] pc, input logic ec, input logic mr);
    req_valid = 1'b1; req_funct3 = f3; req_csr = a; req_rs1_idx = idx;
    req_rs1_data = d; req_pc = pc; req_ecall = ec; req_mret = mr;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_outs"}, {28'd0, csr_wen, resp_valid, redirect_valid, resp_illegal}, 32'd0);
    chk({tag, "_data"}, resp_rdata | redirect_pc | csr_read_addr | csr_write_addr | csr_write_data, 32'd0);
  endtask

  typedef struct {
    logic [2:0] f3; logic [11:0] a; logic [4:0] idx; logic [31:0] d; logic [31:0] pre;
    logic wen; logic [31:0] wdata; logic [31:0] rdata; logic ill;
  } vec_t;
  vec_t vt[12];

  initial begin
    vt[0]  = '{3'b001, 12'h340, 5'd1,  32'hDEADBEEF, 32'h12345678, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0};
    vt[1]  = '{3'b010, 12'h300, 5'd0,  32'h0000FFFF, 32'h00001800, 1'b0, 32'h0,        32'h00001800, 1'b0};
    vt[2]  = '{3'b111, 12'h304, 5'd5,  32'hFFFFFFFF, 32'h000000FF, 1'b1, 32'h000000FA, 32'h000000FF, 1'b0};
    vt[3]  = '{3'b010, 12'h340, 5'd3,  32'h000000F0, 32'h0000000F, 1'b1, 32'h000000FF, 32'h0000000F, 1'b0};
    vt[4]  = '{3'b011, 12'h341, 5'd2,  32'h0000000F, 32'h000000FF, 1'b1, 32'h000000F0, 32'h000000FF, 1'b0};
    vt[5]  = '{3'b101, 12'h340, 5'd31, 32'h0000AAAA, 32'h00000000, 1'b1, 32'h0000001F, 32'h00000000, 1'b0};
    vt[6]  = '{3'b101, 12'h340, 5'd0,  32'h0000AAAA, 32'h00000055, 1'b1, 32'h00000000, 32'h00000055, 1'b0};
    vt[7]  = '{3'b110, 12'h340, 5'd0,  32'hFFFFFFFF, 32'h00000077, 1'b0, 32'h0,        32'h00000077, 1'b0};
    vt[8]  = '{3'b110, 12'h305, 5'd16, 32'h0,        32'h00000003, 1'b1, 32'h00000013, 32'h00000003, 1'b0};
    vt[9]  = '{3'b100, 12'h340, 5'd1,  32'h11111111, 32'h00000099, 1'b0, 32'h0,        32'h0,        1'b1};
    vt[10] = '{3'b000, 12'h340, 5'd1,  32'h22222222, 32'h00000099, 1'b0, 32'h0,        32'h0,        1'b1};
    vt[11] = '{3'b001, 12'h340, 5'd0,  32'h00000000, 32'h00000123, 1'b1, 32'h00000000, 32'h00000123, 1'b0};

    rst = 1'b1;
    drive(3'b000, 12'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    req_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    check_quiet("reset");

    // Zicsr table.
    for (int i = 0; i < 12; i++) begin
      preload(vt[i].a, vt[i].pre);
      if (vt[i].wen) wq.push_back('{vt[i].a, vt[i].wdata});
      rq.push_back('{vt[i].rdata, vt[i].ill});
      drive(vt[i].f3, vt[i].a, vt[i].idx, vt[i].d, 32'h0, 1'b0, 1'b0);
      step();
      req_valid = 1'b0;
      chk($sformatf("v%0d_resp_valid", i), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("v%0d_illegal", i), {31'd0, resp_illegal}, {31'd0, vt[i].ill});
      chk($sformatf("v%0d_rdata", i), resp_rdata, vt[i].rdata);
      chk($sformatf("v%0d_wen", i), {31'd0, csr_wen}, {31'd0, vt[i].wen});
      chk($sformatf("v%0d_wdata", i), csr_write_data, vt[i].wdata);
      chk($sformatf("v%0d_raddr", i), csr_read_addr, vt[i].ill ? 32'd0 : {20'd0, vt[i].a});
      chk($sformatf("v%0d_busy", i), {31'd0, req_ready}, 32'd0);
      step();
      chk($sformatf("v%0d_ready", i), {31'd0, req_ready}, 32'd1);
      chk($sformatf("v%0d_mem", i), csr_mem[vt[i].a], vt[i].wen ? vt[i].wdata : vt[i].pre);
    end

    // ECALL, with mret also set (ecall wins).
    preload(12'h300, 32'h00001808);
    preload(12'h305, 32'h80000201);
    wq.push_back('{12'h341, 32'h80000104});
    wq.push_back('{12'h342, 32'd11});
    wq.push_back('{12'h300, 32'h00001880});
    dq.push_back(32'h80000200);
    drive(3'b000, 12'h0, 5'd0, 32'h0, 32'h80000104, 1'b1, 1'b1);
    step(); req_valid = 1'b0;
    chk("ec_n1_addr", csr_write_addr, 32'h341);
    chk("ec_n1_wen", {31'd0, csr_wen}, 32'd1);
    step();
    chk("ec_n2_data", csr_write_data, 32'd11);
    step();
    chk("ec_n3_data", csr_write_data, 32'h00001880);
    step();
    chk("ec_n4_redir", {31'd0, redirect_valid}, 32'd1);
    chk("ec_n4_pc", redirect_pc, 32'h80000200);
    chk("ec_n4_wen", {31'd0, csr_wen}, 32'd0);
    step();
    chk("ec_n5_ready", {31'd0, req_ready}, 32'd1);
    chk("ec_mepc", csr_mem[12'h341], 32'h80000104);

    // MRET.
    preload(12'h300, 32'h00001880);
    preload(12'h341, 32'h80000108);
    wq.push_back('{12'h300, 32'h00001888});
    dq.push_back(32'h80000108);
    drive(3'b000, 12'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(); req_valid = 1'b0;
    chk("mr_n1_data", csr_write_data, 32'h00001888);
    step();
    chk("mr_n2_redir", {31'd0, redirect_valid}, 32'd1);
    chk("mr_n2_pc", redirect_pc, 32'h80000108);
    step();
    chk("mr_n3_ready", {31'd0, req_ready}, 32'd1);

    // ECALL at a misaligned pc with a new request held throughout; it is taken only at N+5.
    preload(12'h300, 32'h00000008);
    preload(12'h305, 32'h80000000);
    preload(12'h340, 32'h00000042);
    wq.push_back('{12'h341, 32'h80000104});
    wq.push_back('{12'h342, 32'd11});
    wq.push_back('{12'h300, 32'h00001880});
    dq.push_back(32'h80000000);
    drive(3'b000, 12'h0, 5'd0, 32'h0, 32'h80000107, 1'b1, 1'b0);
    step();
    drive(3'b001, 12'h340, 5'd4, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("hold_n%0d_busy", c), {31'd0, req_ready}, 32'd0);
      chk($sformatf("hold_n%0d_noresp", c), {31'd0, resp_valid}, 32'd0);
      step();
    end
    chk("hold_n5_ready", {31'd0, req_ready}, 32'd1);
    wq.push_back('{12'h340, 32'hCAFEF00D});
    rq.push_back('{32'h00000042, 1'b0});
    step(); req_valid = 1'b0;
    chk("hold_n6_resp", {31'd0, resp_valid}, 32'd1);
    chk("hold_n6_rdata", resp_rdata, 32'h00000042);
    step();

    // Reset during T_CAUSE: only the mepc write is expected; mstatus must stay untouched.
    preload(12'h300, 32'h00001808);
    preload(12'h305, 32'h80000400);
    wq.push_back('{12'h341, 32'h80000200});
    drive(3'b000, 12'h0, 5'd0, 32'h0, 32'h80000200, 1'b1, 1'b0);
    step(); req_valid = 1'b0;
    chk("rst_n1_wen", {31'd0, csr_wen}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_quiet("rst_after");
    for (int c = 0; c < 4; c++) step();
    check_quiet("rst_later");
    chk("rst_mstatus", csr_mem[12'h300], 32'h00001808);

    chk("sb_drain", wq.size() + rq.size() + dq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_ctrl.md
# csr_ctrl

Execute-stage CSR access and trap sequencer for the TaoShuRV core; it is the initiator side of the CSR register-file port. It accepts one decoded request at a time from the pipeline: a Zicsr instruction, an ECALL or an MRET. It turns each request into a sequence of single-port CSR reads and writes. For traps and returns it also issues a PC redirect.

## Interface
Parameters:
- XLEN, 32, datapath width; CSR port address/data width.
- ECALL_CAUSE, 11, value written to mcause on ECALL (environment call from M-mode).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept (high only in IDLE).
- req_funct3  in  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
- req_csr  in  12  CSR address.
- req_rs1_idx  in  5  rs1 index, or zimm for immediate forms.
- req_rs1_data  in  XLEN  rs1 value.
- req_pc  in  XLEN  PC of the instruction.
- req_ecall  in  1  request is ECALL.
- req_mret  in  1  request is MRET.
- resp_valid  out  1  one-cycle pulse: CSR instruction complete.
- resp_rdata  out  XLEN  old CSR value, destined for rd.
- resp_illegal  out  1  qualifies resp_valid: funct3 was 000 or 100.
- redirect_valid  out  1  one-cycle pulse: fetch must jump.
- redirect_pc  out  XLEN  jump target.
- csr_wen  out  1  CSR write enable.
- csr_read_addr  out  XLEN  zero-extended 12-bit address.
- csr_write_addr  out  XLEN  zero-extended 12-bit address.
- csr_write_data  out  XLEN  write value.
- csr_read_data  in  XLEN  combinational read result for csr_read_addr in the same cycle.

## Operation
- Handshake: a request is accepted on a cycle with req_valid && req_ready. All request fields are captured into registers on acceptance.
- Request priority: req_ecall > req_mret > Zicsr.
- States: IDLE, CSR, T_EPC, T_CAUSE, T_STAT, T_VEC, R_STAT, R_EPC.
- IDLE -> CSR / T_EPC / R_STAT on acceptance, according to request type.
- CSR (1 cycle), then IDLE:
  - Drive csr_read_addr = write addr = captured CSR.
  - src = rs1_data for funct3 0xx; src = zero-extended zimm for funct3 1xx.
  - New value: RW = src; RS = old | src; RC = old & ~src.
  - csr_wen = 1, except:
    - RS/RC/RSI/RCI with rs1_idx == 0;
    - illegal funct3, which also reads nothing.
  - Pulse resp_valid with resp_rdata = old value (0 if illegal).
- ECALL sequence, one CSR write per state:
  - T_EPC: write mepc (0x341) = pc & ~3.
  - T_CAUSE: write mcause (0x342) = ECALL_CAUSE.
  - T_STAT: read mstatus (0x300) and write it back modified: MPIE (bit 7) = MIE (bit 3); MIE = 0; MPP (bits 12:11) = 2'b11; other bits unchanged.
  - T_VEC: read mtvec (0x305); no write. Pulse redirect_valid with redirect_pc = {mtvec[XLEN-1:2], 2'b00}; exceptions ignore vectored mode. Then IDLE.
- MRET sequence:
  - R_STAT: read/write mstatus: MIE = MPIE; MPIE = 1; MPP = 2'b11.
  - R_EPC: read mepc; no write. Pulse redirect_valid with redirect_pc = mepc & ~3. Then IDLE.
- Port outputs:
  - csr_read_addr and csr_write_addr are 0 in IDLE.
  - csr_write_data is 0 whenever csr_wen = 0.

## Timing
- Reset values: req_ready = 1 (state IDLE); every other output 0.
- Reset mid-sequence: state returns to IDLE on the next edge. No further writes are issued. Writes already committed are not undone.
- Zicsr: accept at cycle N; csr_wen and resp_valid both in cycle N+1; req_ready high again in N+2.
- ECALL: writes in N+1, N+2, N+3; redirect_valid in N+4; ready in N+5.
- MRET: write in N+1; redirect_valid in N+2; ready in N+3.
- req_ready is low in every non-IDLE state. Inputs presented while req_ready is low are ignored; they are not queued.
- resp_valid and redirect_valid are never high in the same cycle.
- At most one csr_wen per cycle. Read and write addresses are equal whenever both are active.

## Test plan
- Reset, then CSRRW 0x340 (mscratch), rs1_data = 0xDEADBEEF, with the CSR model holding 0x12345678 → N+1: csr_wen = 1, write addr 0x340, data 0xDEADBEEF, resp_rdata = 0x12345678.
- CSRRS 0x300 with rs1_idx = 0 (mstatus = 0x1800) → resp_rdata = 0x1800, csr_wen = 0. Then CSRRCI 0x304 with zimm = 5 and mie = 0xFF → write 0xFA.
- ECALL at pc = 0x80000104, mstatus = 0x1808, mtvec = 0x80000201 → writes in order:
  - mepc = 0x80000104;
  - mcause = 11;
  - mstatus = 0x1880.
  Then at N+4: redirect_pc = 0x80000200.
- MRET with mstatus = 0x1880 and mepc = 0x80000108 → mstatus written 0x1888; redirect_pc = 0x80000108 at N+2.
- funct3 = 100 → resp_valid and resp_illegal at N+1, resp_rdata = 0, no csr_wen. A new req_valid held during the ECALL sequence is accepted only when req_ready returns high at N+5.
- Assert rst during T_CAUSE → next cycle IDLE, no mstatus write, no redirect_valid, all outputs 0.
